fetch_prefetch_queue: RTL and testbench

FETCH_PREFETCH_QUEUE -- requirements
Module: fetch_prefetch_queue

---
 rtl/fetch_prefetch_queue.sv | 132 +++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: fetches sequential words from instruction memory into a
// small circular buffer and presents the head to the consumer; Redirect/Halt flush it.
module fetch_prefetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Redirect,
    input  logic [15:0] RedirectPC,
    input  logic        Halt,
    input  logic        Stall,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    input  logic        MemAck,
    input  logic [15:0] MemData,
    output logic        InstructValid,
    output logic [15:0] Instruct,
    output logic [15:0] InstructPC
);

    // state   | meaning
    // IDLE    | no request outstanding; waits for room in the queue
    // REQ     | read outstanding at reqAddr; data is pushed on MemAck
    // DISCARD | read outstanding after a flush; data is dropped on MemAck
    // HALTED  | fetching stopped until the next Redirect

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD, HALTED} state_t;

    state_t        state;
    logic [15:0]   fetchAddr;
    logic [15:0]   reqAddr;
    logic          haltFlag;
    logic [CW-1:0] count;
    logic [PW-1:0] rdPtr;
    logic [PW-1:0] wrPtr;
    logic [15:0]   pcMem   [DEPTH];
    logic [15:0]   wordMem [DEPTH];

    logic headValid;
    logic flush;
    logic push;
    logic pop;
    logic notFull;
    logic roomAfterPush;

    assign headValid     = (count != '0);
    assign flush         = Halt || Redirect;
    assign push          = (state == REQ) && MemAck && !flush;
    assign pop           = headValid && !Stall && !flush;
    assign notFull       = (count < DEPTH_C);
    assign roomAfterPush = ((count + CW'(1)) < DEPTH_C);

    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtr]   <= fetchAddr;
            wordMem[wrPtr] <= MemData;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetchAddr <= '0;
            reqAddr   <= '0;
            haltFlag  <= 1'b0;
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
        end else if (Halt) begin
            haltFlag  <= 1'b1;
            fetchAddr <= '0;
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            // A read completing in this very cycle needs no DISCARD pass.
            case (state)
                IDLE:    state <= HALTED;
                REQ:     state <= MemAck ? HALTED : DISCARD;
                DISCARD: if (MemAck) state <= HALTED;
                default: state <= HALTED;
            endcase
        end else if (Redirect) begin
            haltFlag  <= 1'b0;
            fetchAddr <= RedirectPC;
            count     <= '0;
            rdPtr     <= '0;
            wrPtr     <= '0;
            case (state)
                IDLE:    state <= IDLE;
                REQ:     state <= MemAck ? IDLE : DISCARD;
                DISCARD: if (MemAck) state <= IDLE;
                default: state <= IDLE;
            endcase
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop)  rdPtr <= rdPtr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);

            case (state)
                IDLE: begin
                    if (notFull) begin
                        state   <= REQ;
                        reqAddr <= fetchAddr;
                    end
                end
                REQ: begin
                    if (MemAck) begin
                        fetchAddr <= fetchAddr + 16'd1;
                        if (roomAfterPush) reqAddr <= fetchAddr + 16'd1;
                        else               state   <= IDLE;
                    end
                end
                DISCARD: begin
                    if (MemAck) state <= haltFlag ? HALTED : IDLE;
                end
                default: state <= HALTED;
            endcase
        end
    end

    assign MemReq        = (state == REQ) || (state == DISCARD);
    assign MemAddr       = reqAddr;
    assign InstructValid = headValid;
    assign Instruct      = headValid ? wordMem[rdPtr] : 16'h0000;
    assign InstructPC    = headValid ? pcMem[rdPtr]   : 16'h0000;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a memory responder with programmable ack delay
// and a scoreboard of expected {PC, word} entries checked at the queue head every cycle.
module tb_fetch_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        Redirect;
    logic [15:0] RedirectPC;
    logic        Halt;
    logic        Stall;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic        MemAck;
    logic [15:0] MemData;
    logic        InstructValid;
    logic [15:0] Instruct;
    logic [15:0] InstructPC;

    fetch_prefetch_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .Redirect      (Redirect),
        .RedirectPC    (RedirectPC),
        .Halt          (Halt),
        .Stall         (Stall),
        .MemReq        (MemReq),
        .MemAddr       (MemAddr),
        .MemAck        (MemAck),
        .MemData       (MemData),
        .InstructValid (InstructValid),
        .Instruct      (Instruct),
        .InstructPC    (InstructPC)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] expQ [$];
    logic [15:0] nextPc;
    logic [15:0] discardAddr;
    bit          discardPending;
    bit          modelHalted;
    int          ackDelay;
    int          reqCycles;

    function automatic logic [15:0] memWord(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: answer the memory, drive controls, advance the model, then check the head.
    task automatic step(input bit redir, input logic [15:0] rpc, input bit halt);
        bit ack;
        bit fl;
        ack = 1'b0;
        if (MemReq) begin
            reqCycles++;
            ack = (reqCycles > ackDelay);
            if (ack) reqCycles = 0;
        end else begin
            reqCycles = 0;
        end
        MemAck     = ack;
        MemData    = ack ? memWord(MemAddr) : 16'hDEAD;
        Redirect   = redir;
        RedirectPC = rpc;
        Halt       = halt;
        fl         = redir || halt;

        if (!fl && expQ.size() != 0 && !Stall) void'(expQ.pop_front());
        if (ack) begin
            if (discardPending) begin
                check("discard_addr", MemAddr, discardAddr);
                discardPending = 1'b0;
            end else if (!fl) begin
                check("mem_addr", MemAddr, nextPc);
                expQ.push_back(nextPc);
                nextPc++;
            end
        end
        if (halt) begin
            expQ.delete();
            modelHalted    = 1'b1;
            nextPc         = 16'h0000;
            discardPending = MemReq && !ack;
            discardAddr    = MemAddr;
        end else if (redir) begin
            expQ.delete();
            modelHalted    = 1'b0;
            nextPc         = rpc;
            discardPending = MemReq && !ack;
            discardAddr    = MemAddr;
        end

        @(posedge clk);
        #1;
        check("valid", 16'(InstructValid), 16'(expQ.size() != 0));
        if (expQ.size() != 0) begin
            check("head_pc", InstructPC, expQ[0]);
            check("head_word", Instruct, memWord(expQ[0]));
        end else begin
            check("empty_pc", InstructPC, 16'h0000);
            check("empty_word", Instruct, 16'h0000);
        end
        if (modelHalted && !discardPending) check("halted_noreq", 16'(MemReq), 16'h0000);
    endtask

    task automatic step0();
        step(1'b0, 16'h0000, 1'b0);
    endtask

    // Step until a request is seen that has not yet been counted by the responder.
    task automatic waitFreshReq(input int limit);
        for (int i = 0; i < limit; i++) begin
            if (MemReq && reqCycles == 0) break;
            step0();
        end
        check("wait_req", 16'(MemReq), 16'h0001);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_memreq"}, 16'(MemReq), 16'h0000);
        check({tag, "_memaddr"}, MemAddr, 16'h0000);
        check({tag, "_valid"}, 16'(InstructValid), 16'h0000);
        check({tag, "_instr"}, Instruct, 16'h0000);
        check({tag, "_pc"}, InstructPC, 16'h0000);
    endtask

    initial begin
        rst            = 1'b0;
        Redirect       = 1'b0;
        RedirectPC     = 16'h0000;
        Halt           = 1'b0;
        Stall          = 1'b1;
        MemAck         = 1'b0;
        MemData        = 16'h0000;
        nextPc         = 16'h0000;
        discardAddr    = 16'h0000;
        discardPending = 1'b0;
        modelHalted    = 1'b0;
        ackDelay       = 0;
        reqCycles      = 0;

        #12;
        checkAllZero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Fill with immediate acks while stalled: addresses 0..3, then stop requesting.
        repeat (8) step0();
        check("full_noreq", 16'(MemReq), 16'h0000);
        check("full_valid", 16'(InstructValid), 16'h0001);
        check("full_head_pc", InstructPC, 16'h0000);

        // One pop from a full queue, then exactly one refill request to address 4.
        Stall = 1'b0;
        step0();
        Stall = 1'b1;
        check("pop_head_pc", InstructPC, 16'h0001);
        waitFreshReq(5);
        check("refill_addr", MemAddr, 16'h0004);
        step0();

        // Redirect while a read is held off: old data dropped, restart at 0x0040.
        ackDelay = 3;
        Stall    = 1'b0;
        repeat (6) step0();
        waitFreshReq(20);
        step(1'b1, 16'h0040, 1'b0);
        check("discard_holds_req", 16'(MemReq), 16'h0001);
        repeat (3) step0();
        waitFreshReq(10);
        check("redirect_addr", MemAddr, 16'h0040);
        ackDelay = 0;
        Stall    = 1'b1;
        step0();
        check("redirect_first_pc", InstructPC, 16'h0040);
        repeat (2) step0();

        // Redirect with immediate acks: head valid two edges later.
        step(1'b1, 16'h0100, 1'b0);
        step0();
        step0();
        check("latency_valid", 16'(InstructValid), 16'h0001);
        check("latency_pc", InstructPC, 16'h0100);

        // Address wrap from 0xFFFF to 0x0000.
        step(1'b1, 16'hFFFE, 1'b0);
        repeat (6) step0();
        check("wrap_head", InstructPC, 16'hFFFE);
        Stall = 1'b0;
        step0();
        check("wrap_ffff", InstructPC, 16'hFFFF);
        step0();
        check("wrap_zero", InstructPC, 16'h0000);
        Stall = 1'b1;
        repeat (3) step0();

        // Halt wins over a simultaneous Redirect; a later Redirect resumes fetching.
        ackDelay = 2;
        Stall    = 1'b0;
        waitFreshReq(20);
        step(1'b1, 16'h0077, 1'b1);
        repeat (8) step0();
        check("halt_memreq", 16'(MemReq), 16'h0000);
        check("halt_valid", 16'(InstructValid), 16'h0000);
        step(1'b1, 16'h0010, 1'b0);
        waitFreshReq(10);
        check("resume_addr", MemAddr, 16'h0010);
        repeat (4) step0();

        // Reset in the middle of a held-off read.
        ackDelay = 3;
        waitFreshReq(20);
        #2;
        rst      = 1'b0;
        MemAck   = 1'b0;
        Redirect = 1'b0;
        Halt     = 1'b0;
        #1;
        checkAllZero("midreset");
        expQ.delete();
        nextPc         = 16'h0000;
        discardPending = 1'b0;
        modelHalted    = 1'b0;
        reqCycles      = 0;
        ackDelay       = 0;
        @(negedge clk);
        rst = 1'b1;
        waitFreshReq(5);
        check("post_reset_addr", MemAddr, 16'h0000);
        repeat (3) step0();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
